// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and the round-robin pick function for the UART TX arbiter.
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PTR_W   = $clog2(MAX_REQ);

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // One-hot of the first set request at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int unsigned        idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (32'(ptr) + i) % n;
      if (i < n && !found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART byte handshakes of the UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) ();
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      tx_valid_o;
  logic [DATA_W-1:0]         tx_data_o;
  logic                      tx_ready_i;

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_ready_i,
    input  req_ready_o, tx_valid_o, tx_data_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
    output req_ready_o, tx_valid_o, tx_data_o
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: request vector and pointer in, one-hot grant out.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic [MAX_REQ-1:0] pick_wide;
  logic               unused_pick_hi;

  assign pick_wide      = rr_pick(MAX_REQ'(req), ptr, NUM_REQ);
  assign grant          = pick_wide[NUM_REQ-1:0];
  assign unused_pick_hi = ^pick_wide;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte path.
// Optional forced release on idle owner: UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset_i,
  uart_tx_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               busy_o,
  output logic               timeout_o
);
  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, arb_grant, req_ready;
  logic [PTR_W-1:0]   ptr_q, ptr_d, next_ptr;
  logic               tx_valid_q;
  logic [DATA_W-1:0]  tx_data_q, sel_data;
  logic               out_free, owner_valid, sel_last, load;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (bus.req_valid_i),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    load      = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    next_ptr  = '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = 1'b0;
`endif
    out_free    = !tx_valid_q || bus.tx_ready_i;
    owner_valid = |(grant_q & bus.req_valid_i);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        sel_data = bus.req_data_i[k*DATA_W +: DATA_W];
        sel_last = bus.req_last_i[k];
        next_ptr = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
    case (state_q)
      IDLE: begin
        if (|bus.req_valid_i) begin
          state_d = LOCKED;
          grant_d = arb_grant;
        end
      end
      LOCKED: begin
        req_ready = grant_q & {NUM_REQ{out_free}};
        load      = owner_valid && out_free;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        cnt_d = owner_valid ? '0 : cnt_q + 1'b1;
`endif
        if (load && sel_last) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = next_ptr;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
        end else if (!owner_valid && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // The increment this cycle reaches TIMEOUT_CYCLES: release now.
          state_d   = IDLE;
          grant_d   = '0;
          ptr_d     = next_ptr;
          cnt_d     = '0;
          timeout_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      if (load) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= sel_data;
      end else if (bus.tx_ready_i) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign bus.req_ready_o = req_ready;
  assign bus.tx_valid_o  = tx_valid_q;
  assign bus.tx_data_o   = tx_data_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q == LOCKED) || tx_valid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit bytes).
module tb_uart_tx_arbiter;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] grant_o;
  logic       busy_o, timeout_o;
  int         tests = 0;
  int         fails = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .bus       (bus.slave),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    bus.req_valid_i[k]       = v;
    bus.req_data_i[k*8 +: 8] = d;
    bus.req_last_i[k]        = l;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i         = 1'b1;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    bus.tx_ready_i  = 1'b1;
    step();
    step();
    check("rst_tx_valid", 32'(bus.tx_valid_o), 0);
    check("rst_tx_data", 32'(bus.tx_data_o), 0);
    check("rst_grant", 32'(grant_o), 0);
    check("rst_ready", 32'(bus.req_ready_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_timeout", 32'(timeout_o), 0);
    reset_i = 1'b0;

    // Single requester, 3-byte packet
    set_req(1, 1, 8'h41, 0);
    step();
    check("single_grant0", 32'(grant_o), 32'h2);
    check("single_ready0", 32'(bus.req_ready_o), 32'h2);
    check("single_txv0", 32'(bus.tx_valid_o), 0);
    step();
    check("single_tx41", 32'(bus.tx_data_o), 32'h41);
    check("single_txv1", 32'(bus.tx_valid_o), 1);
    check("single_grant1", 32'(grant_o), 32'h2);
    set_req(1, 1, 8'h42, 0);
    step();
    check("single_tx42", 32'(bus.tx_data_o), 32'h42);
    check("single_grant2", 32'(grant_o), 32'h2);
    set_req(1, 1, 8'h43, 1);
    step();
    check("single_tx43", 32'(bus.tx_data_o), 32'h43);
    check("single_grant_off", 32'(grant_o), 0);
    check("single_busy", 32'(busy_o), 1);
    set_req(1, 0, 8'h00, 0);
    step();
    check("single_drain", 32'(bus.tx_valid_o), 0);
    check("single_idle_busy", 32'(busy_o), 0);

    // Contention between requesters 0 and 2
    do_reset();
    set_req(0, 1, 8'h10, 0);
    set_req(2, 1, 8'h20, 0);
    step();
    check("cont_grant0", 32'(grant_o), 32'h1);
    step();
    check("cont_tx10", 32'(bus.tx_data_o), 32'h10);
    set_req(0, 1, 8'h11, 1);
    step();
    check("cont_tx11", 32'(bus.tx_data_o), 32'h11);
    check("cont_idle_gap", 32'(grant_o), 0);
    set_req(0, 0, 8'h00, 0);
    step();
    check("cont_grant2", 32'(grant_o), 32'h4);
    check("cont_ready2", 32'(bus.req_ready_o), 32'h4);
    check("cont_gap_txv", 32'(bus.tx_valid_o), 0);
    step();
    check("cont_tx20", 32'(bus.tx_data_o), 32'h20);
    set_req(2, 1, 8'h21, 1);
    step();
    check("cont_tx21", 32'(bus.tx_data_o), 32'h21);
    check("cont_grant_off", 32'(grant_o), 0);
    set_req(2, 0, 8'h00, 0);
    step();

    // Round-robin with all four sending single-byte packets
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, 1, 8'(8'h30 + k), 1);
    for (int p = 0; p < 8; p++) begin
      step();
      check("rr_grant", 32'(grant_o), 32'(1 << (p % 4)));
      step();
      check("rr_tx", 32'(bus.tx_data_o), 32'(8'h30 + (p % 4)));
      check("rr_release", 32'(grant_o), 0);
    end
    for (int k = 0; k < 4; k++) set_req(k, 0, 8'h00, 0);
    step();

    // Backpressure mid-packet on requester 3
    do_reset();
    set_req(3, 1, 8'h51, 0);
    step();
    check("bp_grant", 32'(grant_o), 32'h8);
    step();
    check("bp_tx51", 32'(bus.tx_data_o), 32'h51);
    set_req(3, 1, 8'h52, 0);
    bus.tx_ready_i = 1'b0;
    #1;
    check("bp_ready_low", 32'(bus.req_ready_o), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 32'(bus.tx_valid_o), 1);
      check("bp_hold_data", 32'(bus.tx_data_o), 32'h51);
      check("bp_hold_ready", 32'(bus.req_ready_o), 0);
    end
    bus.tx_ready_i = 1'b1;
    #1;
    check("bp_ready_back", 32'(bus.req_ready_o), 32'h8);
    step();
    check("bp_tx52", 32'(bus.tx_data_o), 32'h52);
    check("bp_txv52", 32'(bus.tx_valid_o), 1);
    set_req(3, 1, 8'h53, 0);
    step();
    check("bp_tx53", 32'(bus.tx_data_o), 32'h53);
    set_req(3, 1, 8'h54, 1);
    step();
    check("bp_tx54", 32'(bus.tx_data_o), 32'h54);
    check("bp_grant_off", 32'(grant_o), 0);
    set_req(3, 0, 8'h00, 0);
    step();
    check("bp_drain", 32'(bus.tx_valid_o), 0);

    // Reset in the middle of a 4-byte packet
    do_reset();
    set_req(1, 1, 8'h61, 0);
    step();
    step();
    check("mr_tx61", 32'(bus.tx_data_o), 32'h61);
    set_req(1, 1, 8'h62, 0);
    step();
    check("mr_tx62", 32'(bus.tx_data_o), 32'h62);
    set_req(1, 1, 8'h63, 0);
    reset_i = 1'b1;
    step();
    check("mr_txv", 32'(bus.tx_valid_o), 0);
    check("mr_txd", 32'(bus.tx_data_o), 0);
    check("mr_grant", 32'(grant_o), 0);
    check("mr_ready", 32'(bus.req_ready_o), 0);
    check("mr_busy", 32'(busy_o), 0);
    check("mr_timeout", 32'(timeout_o), 0);
    reset_i = 1'b0;
    set_req(1, 0, 8'h00, 0);
    set_req(0, 1, 8'h70, 1);
    set_req(2, 1, 8'h72, 1);
    step();
    check("mr_ptr0_grant", 32'(grant_o), 32'h1);
    step();
    check("mr_tx70", 32'(bus.tx_data_o), 32'h70);
    set_req(0, 0, 8'h00, 0);
    set_req(2, 0, 8'h00, 0);
    step();

    // Owner stalls mid-packet while requester 1 waits
    do_reset();
    set_req(0, 1, 8'h81, 0);
    step();
    check("to_grant", 32'(grant_o), 32'h1);
    step();
    check("to_tx81", 32'(bus.tx_data_o), 32'h81);
    set_req(0, 0, 8'h81, 0);
    set_req(1, 1, 8'h82, 1);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step();
      check("to_wait_grant", 32'(grant_o), 32'h1);
      check("to_wait_pulse", 32'(timeout_o), 0);
    end
    step();
    check("to_pulse", 32'(timeout_o), 1);
    check("to_released", 32'(grant_o), 0);
    step();
    check("to_pulse_end", 32'(timeout_o), 0);
    check("to_next_owner", 32'(grant_o), 32'h2);
`else
    repeat (120) step();
    check("hold_grant", 32'(grant_o), 32'h1);
    check("hold_ready", 32'(bus.req_ready_o), 32'h1);
    check("hold_busy", 32'(busy_o), 1);
    check("hold_timeout", 32'(timeout_o), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path of the soc between NUM_REQ byte-stream requesters, e.g. CPU console, debug monitor and status reporter.
- Uses round-robin arbitration with packet lock: a grant is held from the first byte through the byte flagged last.
- Drives the uart_tx byte interface through a one-entry registered output stage.
- Sits between the requesters and the UART TX serializer feeding the TX pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- TIMEOUT_CYCLES, 1024, idle cycles before a forced grant release (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester byte valid.
- req_data_i  input  NUM_REQ*DATA_W  packed bytes; requester k occupies bits [k*DATA_W +: DATA_W].
- req_last_i  input  NUM_REQ  byte is the final byte of its packet.
- req_ready_o  output  NUM_REQ  per-requester accept.
- tx_valid_o  output  1  byte available to the UART.
- tx_data_o  output  DATA_W  byte to the UART.
- tx_ready_i  input  1  UART accepts the byte.
- grant_o  output  NUM_REQ  one-hot current owner; all zero when idle.
- busy_o  output  1  high in LOCKED state or while tx_valid_o is high.
- timeout_o  output  1  one-cycle pulse on forced release; tied 0 when the feature is compiled out.

Behaviour:
- Clock and reset: one clock, clk. reset_i is synchronous and active-high.
- Reset values: tx_valid_o=0, tx_data_o=0, grant_o=0, req_ready_o=0, busy_o=0, timeout_o=0, rr pointer=0, state=IDLE. Reset discards any byte held in the output register.
- Transfer rules:
  - Requester side: a transfer occurs when req_valid_i[k] && req_ready_o[k].
  - UART side: a transfer occurs when tx_valid_o && tx_ready_i.
  - Requesters must hold valid, data and last stable until accepted.
- out_free = !tx_valid_o || tx_ready_i.
- States:
  - IDLE:
    - req_ready_o=0.
    - If any req_valid_i is set, pick the first set bit scanning from ptr upward, modulo NUM_REQ.
    - Register grant_o to that one-hot and go to LOCKED. Arbitration costs one cycle.
  - LOCKED (owner g):
    - req_ready_o[g] = out_free. All other ready bits are 0.
    - On an accepted byte: the output register loads the data and tx_valid_o is set on the next cycle.
    - If the accepted byte has req_last_i[g] set: grant_o clears to 0, ptr becomes (g+1) mod NUM_REQ, and the state returns to IDLE.
    - Owner drops valid mid-packet: the grant is held and other requesters wait (without the optional feature).
- Output register:
  - A UART transfer with no simultaneous load clears tx_valid_o.
  - A UART transfer with a simultaneous load keeps tx_valid_o=1 with the new data, giving full throughput.
  - tx_data_o holds its value while tx_valid_o=0.
- Latency: req_valid_i asserted at cycle 0 in IDLE gives grant_o at cycle 1, accept at cycle 1, and tx_valid_o at cycle 2.
- Back-to-back packets: one idle arbitration cycle between the last byte of one packet and the first accept of the next.
- Single-byte packet (last on the first byte): the grant lasts exactly one cycle.
- Requester valid with last set while not granted: ignored until granted.
- Reset mid-packet: immediate return to IDLE and ptr=0. The partially sent packet is the requester's concern.
- Fairness: a continuously requesting port waits for at most NUM_REQ-1 other packets.

Optional Feature:
- Macro: UART_TX_ARBITER_TIMEOUT_EN.
- Defined:
  - In LOCKED, a counter of width $clog2(TIMEOUT_CYCLES+1) increments each cycle the owner's req_valid_i is 0.
  - The counter resets to 0 on any owner valid.
  - On reaching TIMEOUT_CYCLES: release the grant, advance ptr past the owner, return to IDLE, and pulse timeout_o for one cycle.
- Undefined: no counter; the grant is held until the last byte; timeout_o=0.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum arb_state_t {IDLE, LOCKED};
  - localparam MAX_REQ=8;
  - the function rr_pick(req, ptr), returning a one-hot.
- Sub-module rr_arbiter (NUM_REQ): combinational request vector plus pointer in, one-hot grant out. Instanced once and reusable elsewhere in the soc.

Test Plan:
- Single requester: req 1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_ready_i=1 → tx_data_o shows 0x41..0x43 on consecutive cycles starting cycle 2; grant_o=0010 for 3 cycles then 0.
- Contention: reqs 0 and 2 both valid with 2-byte packets, ptr=0 → req 0 packet completes fully, then one idle cycle, then req 2. No interleaving on tx_data_o.
- Round-robin fairness: all 4 requesters continuously send 1-byte packets → grant order 0,1,2,3,0… and each port gets exactly 1 of every 4 packets.
- Backpressure: tx_ready_i low for 5 cycles mid-packet → tx_valid_o held, tx_data_o stable, req_ready_o[g]=0; resume loses or duplicates no bytes.
- Reset mid-packet: assert reset_i for 1 cycle after byte 2 of 4 → next cycle all outputs 0 and ptr=0; a new request is granted normally.
- Timeout (macro defined, TIMEOUT_CYCLES=16): owner drops valid after byte 1 → timeout_o pulses at idle cycle 16, grant passes to the waiting requester. Macro undefined: grant held 100+ cycles.
